// File: rtl/png_pkg.sv
// Shared constants, encodings and the byte-wise CRC-32 step used by the PNG chunk sequencer.
package png_pkg;

    localparam int unsigned DATA_WD     = 32;
    localparam int unsigned NUM_WD      = 2;
    localparam int unsigned SIZE_PIC_WD = 32;

    localparam logic [31:0] PNG_SIG0  = 32'h89504E47;
    localparam logic [31:0] PNG_SIG1  = 32'h0D0A1A0A;
    localparam logic [31:0] TYPE_IHDR = 32'h49484452;
    localparam logic [31:0] TYPE_IDAT = 32'h49444154;
    localparam logic [31:0] TYPE_IEND = 32'h49454E44;
    localparam logic [31:0] IHDR_LEN  = 32'h0000000D;
    // bit depth 8, colour type 6 (RGBA), compression 0, filter 0
    localparam logic [31:0] IHDR_TAIL = 32'h08060000;
    localparam logic [31:0] CRC_POLY  = 32'hEDB88320;

    typedef enum logic [2:0] {
        StIdle,
        StSig,
        StLen,
        StType,
        StBody,
        StCwait,
        StCrc
    } state_e;

    typedef enum logic [1:0] {
        ChIhdr,
        ChIdat,
        ChIend
    } chunk_e;

    // Reflected CRC-32 over num+1 MSB-aligned bytes, first byte in bits [31:24].
    function automatic logic [31:0] crc32_word(input logic [31:0] crc,
                                               input logic [31:0] dat,
                                               input logic [1:0]  num);
        logic [31:0] c;
        c = crc;
        for (int b = 0; b < 4; b++) begin
            if (b <= int'(num)) begin
                c = c ^ {24'h0, dat[31-8*b -: 8]};
                for (int k = 0; k < 8; k++) begin
                    c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
                end
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/png_chunk_ctrl_if.sv
// Valid/ready word stream carrying data, MSB-aligned byte count and a last marker.
interface png_chunk_ctrl_if;
    import png_pkg::*;

    logic               val;
    logic [DATA_WD-1:0] dat;
    logic [NUM_WD-1:0]  num;
    logic               lst;
    logic               rdy;

    modport master (output val, dat, num, lst, input rdy);
    modport slave  (input val, dat, num, lst, output rdy);

endinterface

// File: rtl/crc32_core.sv
// Word-at-a-time PNG CRC-32; done pulses one cycle after the last word with the final CRC.
module crc32_core
    import png_pkg::*;
(
    input  logic               clk,
    input  logic               rstn,
    input  logic               start_i,
    input  logic               val_i,
    input  logic [DATA_WD-1:0] dat_i,
    input  logic [NUM_WD-1:0]  num_i,
    input  logic               lst_i,
    output logic               done_o,
    output logic [31:0]        crc_o
);

    logic [31:0] crc_q;
    logic [31:0] res_q;
    logic        done_q;
    logic [31:0] crc_nxt;

    always_comb begin
        crc_nxt = crc32_word(crc_q, dat_i, num_i);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            crc_q  <= '0;
            res_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= val_i & lst_i;
            if (start_i) begin
                crc_q <= '1;
            end else if (val_i) begin
                crc_q <= crc_nxt;
            end
            if (val_i && lst_i) begin
                res_q <= ~crc_nxt;
            end
        end
    end

    assign done_o = done_q;
    assign crc_o  = res_q;

endmodule

// File: rtl/png_chunk_ctrl.sv
// Emits signature, IHDR, IDAT (payload pass-through) and IEND chunks, each closed by its CRC.
module png_chunk_ctrl
    import png_pkg::*;
(
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [SIZE_PIC_WD-1:0] w_i,
    input  logic [SIZE_PIC_WD-1:0] h_i,
    input  logic [SIZE_PIC_WD-1:0] idat_len_i,
    input  logic                   start_i,
    png_chunk_ctrl_if.slave        dat,
    png_chunk_ctrl_if.master       out,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o
);

    state_e state_q, state_d;
    chunk_e chunk_q, chunk_d;
    logic [1:0] idx_q, idx_d;

    logic [SIZE_PIC_WD-1:0] w_q, h_q, len_q;
    logic [31:0]            crc_q;
    logic [31:0]            byte_cnt_q;
    logic [31:0]            byte_sum;
    logic                   err_q;

    logic               hs;
    logic               empty_idat;
    logic               idat_body;
    logic               crc_start;
    logic               crc_val;
    logic [DATA_WD-1:0] crc_dat;
    logic [NUM_WD-1:0]  crc_num;
    logic               crc_lst;
    logic               crc_done;
    logic [31:0]        crc_res;

    assign hs         = out.val & out.rdy;
    assign empty_idat = (len_q == '0);
    assign idat_body  = (state_q == StBody) && (chunk_q == ChIdat);
    assign byte_sum   = byte_cnt_q + {{(32 - NUM_WD){1'b0}}, dat.num} + 32'd1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            chunk_q <= ChIhdr;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            chunk_q <= chunk_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        chunk_d = chunk_q;
        idx_d   = idx_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StSig;
                    chunk_d = ChIhdr;
                    idx_d   = '0;
                end
            end
            StSig: begin
                if (hs) begin
                    if (idx_q == 2'd1) begin
                        state_d = StLen;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            StLen: begin
                if (hs) state_d = StType;
            end
            StType: begin
                if (hs) begin
                    idx_d = '0;
                    if (chunk_q == ChIend || (chunk_q == ChIdat && empty_idat)) begin
                        state_d = StCwait;
                    end else begin
                        state_d = StBody;
                    end
                end
            end
            StBody: begin
                if (hs) begin
                    if (chunk_q == ChIhdr) begin
                        if (idx_q == 2'd3) state_d = StCwait;
                        else               idx_d   = idx_q + 2'd1;
                    end else if (dat.lst) begin
                        state_d = StCwait;
                    end
                end
            end
            StCwait: begin
                if (crc_done) state_d = StCrc;
            end
            StCrc: begin
                if (hs) begin
                    unique case (chunk_q)
                        ChIhdr: begin
                            chunk_d = ChIdat;
                            state_d = StLen;
                        end
                        ChIdat: begin
                            chunk_d = ChIend;
                            state_d = StLen;
                        end
                        default: state_d = StIdle;
                    endcase
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        out.val = 1'b0;
        out.dat = '0;
        out.num = '0;
        out.lst = 1'b0;
        dat.rdy = 1'b0;
        unique case (state_q)
            StSig: begin
                out.val = 1'b1;
                out.num = 2'd3;
                out.dat = idx_q[0] ? PNG_SIG1 : PNG_SIG0;
            end
            StLen: begin
                out.val = 1'b1;
                out.num = 2'd3;
                unique case (chunk_q)
                    ChIhdr:  out.dat = IHDR_LEN;
                    ChIdat:  out.dat = len_q;
                    default: out.dat = '0;
                endcase
            end
            StType: begin
                out.val = 1'b1;
                out.num = 2'd3;
                unique case (chunk_q)
                    ChIhdr:  out.dat = TYPE_IHDR;
                    ChIdat:  out.dat = TYPE_IDAT;
                    default: out.dat = TYPE_IEND;
                endcase
            end
            StBody: begin
                if (chunk_q == ChIhdr) begin
                    out.val = 1'b1;
                    out.num = 2'd3;
                    unique case (idx_q)
                        2'd0: out.dat = w_q;
                        2'd1: out.dat = h_q;
                        2'd2: out.dat = IHDR_TAIL;
                        default: begin
                            out.dat = '0;
                            out.num = 2'd0;
                        end
                    endcase
                end else begin
                    out.val = dat.val;
                    out.dat = dat.dat;
                    out.num = dat.num;
                    dat.rdy = out.rdy;
                end
            end
            StCrc: begin
                out.val = 1'b1;
                out.num = 2'd3;
                out.dat = crc_q;
                out.lst = (chunk_q == ChIend);
            end
            default: ;
        endcase
    end

    always_comb begin
        crc_start = hs && (state_q == StLen);
        crc_val   = hs && (state_q == StType || state_q == StBody);
        crc_dat   = out.dat;
        crc_num   = out.num;
        crc_lst   = 1'b0;
        if (crc_val) begin
            if (state_q == StType) begin
                crc_lst = (chunk_q == ChIend) || (chunk_q == ChIdat && empty_idat);
            end else if (chunk_q == ChIhdr) begin
                crc_lst = (idx_q == 2'd3);
            end else begin
                crc_lst = dat.lst;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_q        <= '0;
            h_q        <= '0;
            len_q      <= '0;
            crc_q      <= '0;
            byte_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            if (state_q == StIdle && start_i) begin
                w_q        <= w_i;
                h_q        <= h_i;
                len_q      <= idat_len_i;
                byte_cnt_q <= '0;
                err_q      <= 1'b0;
            end
            if (idat_body && hs) begin
                byte_cnt_q <= byte_sum;
                if (dat.lst && byte_sum != len_q) err_q <= 1'b1;
            end
            if (state_q == StCwait && crc_done) begin
                crc_q <= crc_res;
            end
        end
    end

    assign busy_o = (state_q != StIdle);
    assign done_o = hs && (state_q == StCrc) && (chunk_q == ChIend);
    assign err_o  = err_q;

    crc32_core u_crc32_core (
        .clk     (clk),
        .rstn    (rstn),
        .start_i (crc_start),
        .val_i   (crc_val),
        .dat_i   (crc_dat),
        .num_i   (crc_num),
        .lst_i   (crc_lst),
        .done_o  (crc_done),
        .crc_o   (crc_res)
    );

endmodule

// File: tb/tb_png_chunk_ctrl.sv
// Directed bench for png_chunk_ctrl: golden word sequences built from a bench-side CRC model.
module tb_png_chunk_ctrl;

    typedef logic [34:0] word_t; // {lst, num, dat}

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] w_i, h_i, idat_len_i;
    logic        start_i;
    logic        busy_o, done_o, err_o;

    png_chunk_ctrl_if dat_if ();
    png_chunk_ctrl_if out_if ();

    png_chunk_ctrl dut (
        .clk        (clk),
        .rstn       (rstn),
        .w_i        (w_i),
        .h_i        (h_i),
        .idat_len_i (idat_len_i),
        .start_i    (start_i),
        .dat        (dat_if),
        .out        (out_if),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    word_t got_q[$], exp_q[$], ref_q[$], pay_q[$], pay_src[$];
    logic [7:0] cb[$];
    bit    pay_taken = 1'b0;
    bit    rand_rdy  = 1'b0;
    bit    frame_done;
    int    done_cnt, crc_val_cnt, rdy_cnt, hold_viol;
    word_t first_word;
    logic  first_val;
    logic [35:0] prev_word;
    bit    prev_stall = 1'b0;

    // Payload source and downstream ready; a word is popped once its handshake was seen.
    always @(posedge clk) begin
        if (pay_taken && pay_q.size() > 0) void'(pay_q.pop_front());
        #1;
        if (pay_q.size() > 0) begin
            dat_if.val = 1'b1;
            dat_if.lst = pay_q[0][34];
            dat_if.num = pay_q[0][33:32];
            dat_if.dat = pay_q[0][31:0];
        end else begin
            dat_if.val = 1'b0;
            dat_if.lst = 1'b0;
            dat_if.num = 2'd0;
            dat_if.dat = 32'h0;
        end
        out_if.rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
        pay_taken = dat_if.val & dat_if.rdy;
        if (out_if.val && out_if.rdy) got_q.push_back({out_if.lst, out_if.num, out_if.dat});
        if (done_o) done_cnt++;
        if (dut.crc_val) crc_val_cnt++;
        if (dat_if.rdy) rdy_cnt++;
        if (rstn && prev_stall &&
            {out_if.val, out_if.lst, out_if.num, out_if.dat} !== prev_word) hold_viol++;
        prev_stall = rstn && out_if.val && !out_if.rdy;
        prev_word  = {out_if.val, out_if.lst, out_if.num, out_if.dat};
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [31:0] crc_model();
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (cb[i]) begin
            c = c ^ {24'h0, cb[i]};
            for (int k = 0; k < 8; k++) c = (c >> 1) ^ (c[0] ? 32'hEDB88320 : 32'h0);
        end
        return ~c;
    endfunction

    task automatic add_cov(input logic [31:0] d, input logic [1:0] n);
        exp_q.push_back({1'b0, n, d});
        for (int b = 0; b <= int'(n); b++) cb.push_back(d[31-8*b -: 8]);
    endtask

    task automatic build_exp(input logic [31:0] w, input logic [31:0] h, input logic [31:0] len);
        exp_q.delete();
        exp_q.push_back({1'b0, 2'd3, 32'h89504E47});
        exp_q.push_back({1'b0, 2'd3, 32'h0D0A1A0A});
        exp_q.push_back({1'b0, 2'd3, 32'h0000000D});
        cb.delete();
        add_cov(32'h49484452, 2'd3);
        add_cov(w, 2'd3);
        add_cov(h, 2'd3);
        add_cov(32'h08060000, 2'd3);
        add_cov(32'h00000000, 2'd0);
        exp_q.push_back({1'b0, 2'd3, crc_model()});
        exp_q.push_back({1'b0, 2'd3, len});
        cb.delete();
        add_cov(32'h49444154, 2'd3);
        if (len != 0) foreach (pay_src[i]) add_cov(pay_src[i][31:0], pay_src[i][33:32]);
        exp_q.push_back({1'b0, 2'd3, crc_model()});
        exp_q.push_back({1'b0, 2'd3, 32'h00000000});
        cb.delete();
        add_cov(32'h49454E44, 2'd3);
        exp_q.push_back({1'b1, 2'd3, crc_model()});
    endtask

    // Starts one frame and waits (bounded) for done; optionally re-pulses start mid-frame.
    task automatic run_frame(input logic [31:0] w, input logic [31:0] h, input logic [31:0] len,
                             input int extra_start);
        int cyc;
        got_q.delete();
        done_cnt = 0; crc_val_cnt = 0; rdy_cnt = 0; hold_viol = 0;
        frame_done = 1'b0;
        @(posedge clk); #1;
        w_i = w; h_i = h; idat_len_i = len; start_i = 1'b1;
        @(posedge clk); #1;
        start_i    = 1'b0;
        first_val  = out_if.val;
        first_word = {out_if.lst, out_if.num, out_if.dat};
        cyc = 1;
        while (!frame_done && cyc < 2000) begin
            start_i = (extra_start != 0 && cyc == extra_start);
            if (start_i) w_i = w ^ 32'h0000FFFF;
            @(posedge clk); #1;
            cyc++;
            if (done_cnt != 0) frame_done = 1'b1;
        end
        start_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; start_i = 1'b0; w_i = '0; h_i = '0; idat_len_i = '0;
        #12;
        checks++;
        if ({out_if.val, out_if.lst, out_if.num, out_if.dat, dat_if.rdy, busy_o, done_o, err_o}
            !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got val=%b dat=%h rdy=%b busy=%b done=%b err=%b, want all 0",
                     out_if.val, out_if.dat, dat_if.rdy, busy_o, done_o, err_o);
        end
        @(negedge clk); rstn = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy_o, out_if.val} !== 2'b00) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b val=%b, want 0 0", busy_o, out_if.val);
        end
    endtask

    task automatic test_rgba_1x1();
        pay_src = '{{1'b1, 2'd3, 32'h78DA6300}};
        build_exp(32'd1, 32'd1, 32'd4);
        pay_q = pay_src;
        run_frame(32'd1, 32'd1, 32'd4, 0);
        checks++;
        if (!frame_done) begin errors++; $display("FAIL rgba_timeout: no done_o, want done"); end
        checks++;
        if ({first_val, first_word} !== {1'b1, 1'b0, 2'd3, 32'h89504E47}) begin
            errors++;
            $display("FAIL rgba_first_word: got val=%b %h, want 1 89504E47", first_val, first_word);
        end
        checks++;
        if (got_q.size() != 16) begin
            errors++; $display("FAIL rgba_len: got %0d words, want 16", got_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL rgba_word[%0d]: got %h, want %h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (got_q[8] !== {1'b0, 2'd3, 32'h1F15C489}) begin
            errors++; $display("FAIL rgba_ihdr_crc: got %h, want 1F15C489", got_q[8]);
        end
        checks++;
        if (got_q[15] !== {1'b1, 2'd3, 32'hAE426082}) begin
            errors++; $display("FAIL rgba_iend_crc: got %h, want last AE426082", got_q[15]);
        end
        checks++;
        if (done_cnt != 1) begin errors++; $display("FAIL rgba_done: got %0d, want 1", done_cnt); end
        checks++;
        if (crc_val_cnt != 8) begin
            errors++; $display("FAIL rgba_crc_val: got %0d, want 8", crc_val_cnt);
        end
        checks++;
        if ({busy_o, err_o} !== 2'b00) begin
            errors++; $display("FAIL rgba_end_flags: busy=%b err=%b, want 0 0", busy_o, err_o);
        end
    endtask

    task automatic test_random_rdy();
        pay_src.delete();
        for (int i = 0; i < 9; i++)
            pay_src.push_back({1'b0, 2'd3, 32'h1234ABCD ^ (32'h11111111 * 32'(i))});
        pay_src.push_back({1'b1, 2'd0, 32'hAB000000});
        build_exp(32'd640, 32'd480, 32'd37);
        pay_q = pay_src;
        run_frame(32'd640, 32'd480, 32'd37, 0);
        ref_q = got_q;
        checks++;
        if (!frame_done || got_q.size() != 25) begin
            errors++;
            $display("FAIL rr_ref_run: done=%b words=%0d, want 1 25", frame_done, got_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL rr_model_word[%0d]: got %h, want %h", i, got_q[i], exp_q[i]);
            end
        end
        rand_rdy = 1'b1;
        pay_q = pay_src;
        run_frame(32'd640, 32'd480, 32'd37, 0);
        rand_rdy = 1'b0;
        checks++;
        if (!frame_done || got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rr_rand_run: done=%b words=%0d, want 1 %0d",
                     frame_done, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL rr_rand_word[%0d]: got %h, want %h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (crc_val_cnt != 17) begin
            errors++; $display("FAIL rr_crc_val: got %0d, want 17", crc_val_cnt);
        end
        checks++;
        if (hold_viol != 0) begin
            errors++; $display("FAIL rr_hold: got %0d changes under stall, want 0", hold_viol);
        end
        checks++;
        if ({done_cnt == 1, err_o} !== 2'b10) begin
            errors++; $display("FAIL rr_done_err: done=%0d err=%b, want 1 0", done_cnt, err_o);
        end
    endtask

    task automatic test_len_mismatch();
        pay_src = '{{1'b0, 2'd3, 32'h01020304}, {1'b0, 2'd3, 32'h05060708},
                    {1'b1, 2'd3, 32'h090A0B0C}};
        build_exp(32'd2, 32'd2, 32'd8);
        pay_q = pay_src;
        run_frame(32'd2, 32'd2, 32'd8, 0);
        checks++;
        if (!frame_done || got_q.size() != 18) begin
            errors++;
            $display("FAIL mm_frame: done=%b words=%0d, want 1 18", frame_done, got_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL mm_word[%0d]: got %h, want %h", i, got_q[i], exp_q[i]);
            end
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (err_o !== 1'b1) begin errors++; $display("FAIL mm_err_set: got %b, want 1", err_o); end
        pay_src = '{{1'b1, 2'd3, 32'hCAFEF00D}};
        build_exp(32'd2, 32'd2, 32'd4);
        pay_q = pay_src;
        run_frame(32'd2, 32'd2, 32'd4, 0);
        checks++;
        if ({frame_done, err_o} !== 2'b10) begin
            errors++;
            $display("FAIL mm_err_clear: done=%b err=%b, want 1 0", frame_done, err_o);
        end
    endtask

    task automatic test_empty_idat();
        pay_src = '{{1'b1, 2'd3, 32'hDEADBEEF}};
        build_exp(32'd5, 32'd7, 32'd0);
        pay_q = pay_src;
        run_frame(32'd5, 32'd7, 32'd0, 0);
        checks++;
        if (!frame_done || got_q.size() != 15) begin
            errors++;
            $display("FAIL empty_frame: done=%b words=%0d, want 1 15", frame_done, got_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL empty_word[%0d]: got %h, want %h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (got_q[11] !== {1'b0, 2'd3, 32'h35AF061E}) begin
            errors++; $display("FAIL empty_idat_crc: got %h, want 35AF061E", got_q[11]);
        end
        checks++;
        if (rdy_cnt != 0 || pay_q.size() != 1) begin
            errors++;
            $display("FAIL empty_no_rdy: rdy cycles=%0d left=%0d, want 0 1", rdy_cnt, pay_q.size());
        end
        pay_q.delete();
    endtask

    task automatic test_start_while_busy();
        pay_src = '{{1'b1, 2'd1, 32'h55AA0000}};
        build_exp(32'd2, 32'd3, 32'd2);
        pay_q = pay_src;
        run_frame(32'd2, 32'd3, 32'd2, 5);
        checks++;
        if (!frame_done || done_cnt != 1 || got_q.size() != 16) begin
            errors++;
            $display("FAIL busy_frame: done=%b pulses=%0d words=%0d, want 1 1 16",
                     frame_done, done_cnt, got_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL busy_word[%0d]: got %h, want %h", i, got_q[i], exp_q[i]);
            end
        end
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if ({busy_o, out_if.val} !== 2'b00 || got_q.size() != 16) begin
            errors++;
            $display("FAIL busy_second_frame: busy=%b val=%b words=%0d, want 0 0 16",
                     busy_o, out_if.val, got_q.size());
        end
    endtask

    task automatic test_reset_mid_frame();
        bit seen;
        pay_src.delete();
        for (int i = 0; i < 6; i++) pay_src.push_back({1'b0, 2'd3, 32'h0F0F0F0F + 32'(i)});
        pay_src.push_back({1'b1, 2'd3, 32'hFFFFFFFF});
        pay_q = pay_src;
        @(posedge clk); #1;
        w_i = 32'd9; h_i = 32'd9; idat_len_i = 32'd28; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (dat_if.rdy && dat_if.val) seen = 1'b1;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL rst_reach_body: got no IDAT body, want body"); end
        @(negedge clk);
        rstn = 1'b0;
        #1;
        checks++;
        if ({out_if.val, out_if.lst, out_if.num, out_if.dat, dat_if.rdy, busy_o, done_o, err_o}
            !== '0) begin
            errors++;
            $display("FAIL rst_outputs_now: val=%b dat=%h rdy=%b busy=%b, want all 0",
                     out_if.val, out_if.dat, dat_if.rdy, busy_o);
        end
        repeat (2) @(negedge clk);
        checks++;
        if ({out_if.val, out_if.dat, dat_if.rdy, busy_o, done_o} !== '0) begin
            errors++;
            $display("FAIL rst_outputs_held: val=%b dat=%h rdy=%b busy=%b, want all 0",
                     out_if.val, out_if.dat, dat_if.rdy, busy_o);
        end
        pay_q.delete();
        rstn = 1'b1;
        pay_src = '{{1'b1, 2'd3, 32'h78DA6300}};
        build_exp(32'd1, 32'd1, 32'd4);
        pay_q = pay_src;
        run_frame(32'd1, 32'd1, 32'd4, 0);
        checks++;
        if (!frame_done || done_cnt != 1 || got_q.size() != 16) begin
            errors++;
            $display("FAIL rst_second_frame: done=%b pulses=%0d words=%0d, want 1 1 16",
                     frame_done, done_cnt, got_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL rst_word[%0d]: got %h, want %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rgba_1x1();
        test_random_rdy();
        test_len_mismatch();
        test_empty_idat();
        test_start_while_busy();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
